// File: rtl/weight_store_loader_if.sv
// rtl/weight_store_loader_if.sv - payload stream, read ports and status between driver and weight_store_loader
interface weight_store_loader_if #(
  parameter int WEIGHT_AW = 13,
  parameter int BIAS_AW   = 4
);
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic                 reload;
  logic [WEIGHT_AW-1:0] weight_addr;
  logic [7:0]           weight_data;
  logic [BIAS_AW-1:0]   bias_addr;
  logic [31:0]          bias_data;
  logic                 weights_ready;
  logic                 loading;
  logic                 load_error;
  logic [13:0]          byte_count;

  modport master (
    output rx_data, rx_valid, reload, weight_addr, bias_addr,
    input  weight_data, bias_data, weights_ready, loading, load_error, byte_count
  );

  modport slave (
    input  rx_data, rx_valid, reload, weight_addr, bias_addr,
    output weight_data, bias_data, weights_ready, loading, load_error, byte_count
  );
endinterface

// File: rtl/weight_store_loader.sv
// rtl/weight_store_loader.sv - fills weight RAM and bias registers from a byte stream, serves registered reads
// Optional payload checksum byte: WEIGHT_LOADER_CHECKSUM_EN
module weight_store_loader #(
  parameter int NUM_CLASSES = 10,
  parameter int NUM_PIXELS  = 784,
  parameter int WEIGHT_AW   = 13,
  parameter int BIAS_AW     = 4
) (
  input logic clk,
  input logic rst,
  weight_store_loader_if.slave bus
);
  localparam int NUM_WEIGHTS = NUM_CLASSES * NUM_PIXELS;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  localparam int TOTAL_BYTES = NUM_WEIGHTS + 4 * NUM_CLASSES + 1;
`else
  localparam int TOTAL_BYTES = NUM_WEIGHTS + 4 * NUM_CLASSES;
`endif

  typedef enum logic [1:0] {LOAD_W, LOAD_B, CHECK, DONE} state_t;
  state_t state, next_state;

  logic [WEIGHT_AW-1:0] wptr;
  logic [BIAS_AW-1:0]   bptr;
  logic [1:0]           lane;
  logic [23:0]          asm_word;
  logic [13:0]          byte_count;
  logic                 weights_ready;
  logic                 loading;
  logic                 load_error;
  logic                 ready_d;
  logic                 loading_d;
  logic [7:0]           weight_data;
  logic [31:0]          bias_data;
  logic [7:0]           mem  [NUM_WEIGHTS];
  logic [31:0]          bias [NUM_CLASSES];
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [7:0]           sum;
  logic                 error_d;
`endif

  logic accept;
  logic last_weight;
  logic last_bias;

  // reload wins over a coincident byte; DONE ignores the stream
  assign accept      = bus.rx_valid && !bus.reload && (state != DONE);
  assign last_weight = (wptr == WEIGHT_AW'(NUM_WEIGHTS - 1));
  assign last_bias   = (lane == 2'd3) && (bptr == BIAS_AW'(NUM_CLASSES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD_W;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (bus.reload) begin
      next_state = LOAD_W;
    end else if (bus.rx_valid) begin
      case (state)
        LOAD_W: if (last_weight) next_state = LOAD_B;
        LOAD_B: begin
          if (last_bias) begin
`ifdef WEIGHT_LOADER_CHECKSUM_EN
            next_state = CHECK;
`else
            next_state = DONE;
`endif
          end
        end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        CHECK:  next_state = DONE;
`endif
        default: ;
      endcase
    end
  end

  // status flags are computed from next_state so the flops line up with the state register
  always_comb begin
    loading_d = (next_state == LOAD_W) || (next_state == LOAD_B);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    error_d = load_error;
    if (bus.reload) begin
      error_d = 1'b0;
    end else if ((state == CHECK) && bus.rx_valid && (bus.rx_data != sum)) begin
      error_d = 1'b1;
    end
    ready_d = (next_state == DONE) && !error_d;
`else
    ready_d = (next_state == DONE);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr          <= '0;
      bptr          <= '0;
      lane          <= 2'd0;
      byte_count    <= 14'd0;
      weights_ready <= 1'b0;
      loading       <= 1'b1;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      sum           <= 8'd0;
      load_error    <= 1'b0;
`endif
    end else begin
      weights_ready <= ready_d;
      loading       <= loading_d;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      load_error    <= error_d;
`endif
      if (bus.reload) begin
        wptr       <= '0;
        bptr       <= '0;
        lane       <= 2'd0;
        byte_count <= 14'd0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        sum        <= 8'd0;
`endif
      end else if (accept) begin
        if (byte_count != 14'(TOTAL_BYTES)) begin
          byte_count <= byte_count + 14'd1;
        end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        sum <= sum + bus.rx_data;
`endif
        case (state)
          LOAD_W: begin
            wptr <= wptr + WEIGHT_AW'(1);
            if (last_weight) begin
              bptr <= '0;
              lane <= 2'd0;
            end
          end
          LOAD_B: begin
            lane <= lane + 2'd1;
            if (lane == 2'd3) bptr <= bptr + BIAS_AW'(1);
          end
          default: ;
        endcase
      end
    end
  end

`ifndef WEIGHT_LOADER_CHECKSUM_EN
  assign load_error = 1'b0;
`endif

  // storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (accept && (state == LOAD_W)) begin
      mem[wptr] <= bus.rx_data;
    end
    if (accept && (state == LOAD_B)) begin
      asm_word <= {bus.rx_data, asm_word[23:8]};
      if (lane == 2'd3) bias[bptr] <= {bus.rx_data, asm_word};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      weight_data <= 8'h00;
      bias_data   <= 32'h0;
    end else begin
      weight_data <= (bus.weight_addr < WEIGHT_AW'(NUM_WEIGHTS)) ? mem[bus.weight_addr] : 8'h00;
      bias_data   <= (bus.bias_addr < BIAS_AW'(NUM_CLASSES)) ? bias[bus.bias_addr] : 32'h0;
    end
  end

  assign bus.weight_data   = weight_data;
  assign bus.bias_data     = bias_data;
  assign bus.weights_ready = weights_ready;
  assign bus.loading       = loading;
  assign bus.load_error    = load_error;
  assign bus.byte_count    = byte_count;
endmodule

// File: tb/tb_weight_store_loader.sv
// tb/tb_weight_store_loader.sv - randomized payload loads of weight_store_loader checked against a payload-level model
module tb_weight_store_loader;
  localparam int NW = 7840;
  localparam int NB = 10;
  localparam int PAYLOAD = NW + 4 * NB;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  localparam int TOTAL = PAYLOAD + 1;
`else
  localparam int TOTAL = PAYLOAD;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  byte unsigned pay [0:PAYLOAD];

  always #5 clk = ~clk;

  weight_store_loader_if #(.WEIGHT_AW(13), .BIAS_AW(4)) bus ();
  weight_store_loader dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_w(input int a);
    if (a >= NW) return 32'h0;
    return 32'(pay[a]);
  endfunction

  function automatic logic [31:0] exp_b(input int k);
    if (k >= NB) return 32'h0;
    return {pay[NW+4*k+3], pay[NW+4*k+2], pay[NW+4*k+1], pay[NW+4*k]};
  endfunction

  task automatic fill_random();
    for (int i = 0; i < PAYLOAD; i++) pay[i] = 8'($urandom);
  endtask

  task automatic add_sum(input bit corrupt);
    int s = 0;
    for (int i = 0; i < PAYLOAD; i++) s += pay[i];
    pay[PAYLOAD] = 8'(s + int'(corrupt));
  endtask

  task automatic send_stream(input int len, input bit full, input bit corrupt);
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(15) == 0) begin
        @(negedge clk);
        bus.rx_valid = 1'b0;
      end
      @(negedge clk);
      if (full && i == len - 1) check("ready_before_last", bus.weights_ready, 0);
      bus.rx_data  = pay[i];
      bus.rx_valid = 1'b1;
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
    if (full) begin
      check("ready_after_last", bus.weights_ready, 32'(!corrupt));
      check("loading_done", bus.loading, 0);
      check("count_done", bus.byte_count, TOTAL);
      check("error_done", bus.load_error, 32'(corrupt));
    end
  endtask

  task automatic read_w(input int a);
    @(negedge clk);
    bus.weight_addr = 13'(a);
    @(negedge clk);
    check($sformatf("w[%0d]", a), bus.weight_data, exp_w(a));
  endtask

  task automatic read_b(input int k);
    @(negedge clk);
    bus.bias_addr = 4'(k);
    @(negedge clk);
    check($sformatf("b[%0d]", k), bus.bias_data, exp_b(k));
  endtask

  task automatic verify_all();
    read_w(0);
    read_w(NW - 1);
    read_w(NW);
    read_w(8191);
    repeat (24) read_w(int'($urandom_range(NW - 1)));
    for (int k = 0; k < 16; k++) read_b(k);
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    bus.reload = 1'b1;
    @(negedge clk);
    bus.reload = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, bus.weights_ready, 0);
    check({tag, "_loading"}, bus.loading, 1);
    check({tag, "_error"}, bus.load_error, 0);
    check({tag, "_count"}, bus.byte_count, 0);
    check({tag, "_wdata"}, bus.weight_data, 0);
    check({tag, "_bdata"}, bus.bias_data, 0);
  endtask

  initial begin
    byte unsigned old0;
    bus.rx_data     = 8'h00;
    bus.rx_valid    = 1'b0;
    bus.reload      = 1'b0;
    bus.weight_addr = '0;
    bus.bias_addr   = '0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    // ramp load
    for (int i = 0; i < NW; i++) pay[i] = 8'(i % 256);
    for (int k = 0; k < NB; k++)
      for (int j = 0; j < 4; j++) pay[NW+4*k+j] = 8'((k * 1000) >> (8 * j));
    add_sum(1'b0);
    send_stream(TOTAL, 1'b1, 1'b0);
    read_w(785);
    check("ramp_w785", bus.weight_data, 32'h11);
    read_b(3);
    check("ramp_b3", bus.bias_data, 32'd3000);
    verify_all();

    // bytes after DONE are ignored
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.rx_data  = 8'($urandom);
      bus.rx_valid = 1'b1;
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
    check("extra_count", bus.byte_count, TOTAL);
    check("extra_ready", bus.weights_ready, 1);
    verify_all();

    // bias endianness
    pulse_reload();
    check("reload_ready", bus.weights_ready, 0);
    check("reload_count", bus.byte_count, 0);
    check("reload_loading", bus.loading, 1);
    fill_random();
    pay[NW]   = 8'h78; pay[NW+1] = 8'h56; pay[NW+2] = 8'h34; pay[NW+3] = 8'h12;
    for (int j = 4; j < 8; j++) pay[NW+j] = 8'hFF;
    add_sum(1'b0);
    send_stream(TOTAL, 1'b1, 1'b0);
    read_b(0);
    check("endian_b0", bus.bias_data, 32'h12345678);
    read_b(1);
    check("endian_b1", bus.bias_data, 32'hFFFFFFFF);
    verify_all();

    // reload colliding with a byte mid-stream
    pulse_reload();
    old0 = pay[0];
    fill_random();
    send_stream(5000, 1'b0, 1'b0);
    bus.rx_data  = pay[5000];
    bus.rx_valid = 1'b1;
    bus.reload   = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.reload   = 1'b0;
    check("collide_ready", bus.weights_ready, 0);
    check("collide_count", bus.byte_count, 0);
    check("collide_loading", bus.loading, 1);
    fill_random();
    if (pay[0] == old0) pay[0] = old0 ^ 8'hFF;
    add_sum(1'b0);
    send_stream(TOTAL, 1'b1, 1'b0);
    verify_all();

    // async reset after two bytes of bias 4
    pulse_reload();
    fill_random();
    pay[1]  = 8'h5A;
    pay[NW] = 8'h11;
    bus.weight_addr = 13'd1;
    bus.bias_addr   = 4'd0;
    send_stream(NW + 16 + 2, 1'b0, 1'b0);
    check("pre_rst_w1", bus.weight_data, 32'h5A);
    check("pre_rst_b0", bus.bias_data, exp_b(0));
    check("pre_rst_count", bus.byte_count, NW + 18);
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    @(negedge clk);
    rst = 1'b0;
    fill_random();
    add_sum(1'b0);
    send_stream(TOTAL, 1'b1, 1'b0);
    verify_all();

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    // corrupted checksum byte
    pulse_reload();
    fill_random();
    add_sum(1'b1);
    send_stream(TOTAL, 1'b1, 1'b1);
    pulse_reload();
    check("sum_err_cleared", bus.load_error, 0);
    check("sum_err_ready", bus.weights_ready, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/weight_store_loader.md
Name: weight_store_loader

Overview:
- Writer/responder side of the inference weight interface.
- Receives a byte stream (from the UART receiver) and fills 10x784 signed 8-bit weights plus 10 signed 32-bit biases.
- Serves the inference engine's weight_addr/weight_data and bias_addr/bias_data read ports with registered reads.
- Raises weights_ready once the full payload has been stored.

Parameters:
- NUM_CLASSES, 10, number of output classes.
- NUM_PIXELS, 784, weights per class.
- WEIGHT_AW, 13, weight address width (NUM_CLASSES*NUM_PIXELS must fit).
- BIAS_AW, 4, bias address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  incoming payload byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle.
- reload  in  1  one-cycle pulse; discard the current image and restart loading.
- weight_addr  in  WEIGHT_AW  read address from the inference engine.
- weight_data  out  8  registered weight read data.
- bias_addr  in  BIAS_AW  bias read address.
- bias_data  out  32  registered bias read data.
- weights_ready  out  1  payload complete (and valid, if checked).
- loading  out  1  high while in LOAD_W or LOAD_B.
- load_error  out  1  checksum mismatch, sticky until reload or reset.
- byte_count  out  14  payload bytes accepted since the last reload or reset.

Behaviour:
- Reset values: weights_ready=0, loading=1, load_error=0, byte_count=0, weight_data=0, bias_data=0, FSM=LOAD_W, write pointer=0.
- Weight RAM and bias registers are NOT cleared by reset.
- Payload order:
  - 7840 weight bytes, class-major: address = class*784 + pixel.
  - Then 10 biases, 4 bytes each, little-endian, bias 0 first.
- FSM states: LOAD_W, LOAD_B, CHECK (only with the optional feature), DONE.
- LOAD_W:
  - Each rx_valid writes rx_data to RAM[wptr], increments wptr and byte_count.
  - After the byte at wptr=7839 is written: go to LOAD_B, set bptr=0, set byte-lane=0.
- LOAD_B:
  - Bytes shift into a 32-bit assembly register, lane 0 = bits [7:0].
  - On lane 3 the assembled word is written to bias[bptr], bptr increments, lane returns to 0.
  - After bias 9 is written: go to DONE (or CHECK).
- DONE:
  - weights_ready=1 and loading=0, both registered and asserted the cycle after the final write.
  - rx_valid is ignored; byte_count holds.
- Read ports:
  - 1-cycle latency: weight_data = RAM[weight_addr] from the previous edge; bias_data likewise.
  - Reads are served in every state; data is only meaningful once weights_ready=1.
  - weight_addr >= 7840 returns 0; bias_addr >= 10 returns 0.
- reload:
  - In any state, on the next edge: FSM=LOAD_W, wptr=0, byte_count=0, weights_ready=0, load_error=0, loading=1.
  - If reload and rx_valid occur in the same cycle, reload wins and the byte is dropped.
- A partial bias word, or a partial stream interrupted by reload, is discarded. Previously written RAM contents stay but are overwritten by the new stream.
- Async reset mid-load behaves identically to reload, plus outputs return to their reset values immediately.
- byte_count saturates at 7880 (7881 with checksum).

Optional Feature:
- Macro: WEIGHT_LOADER_CHECKSUM_EN.
- Defined:
  - The payload is followed by one checksum byte equal to the 8-bit modulo-256 sum of all 7880 payload bytes.
  - FSM passes LOAD_B -> CHECK; the next rx_valid byte is compared against the running sum.
  - Match: go to DONE with weights_ready=1.
  - Mismatch: go to DONE with weights_ready=0 and load_error=1.
  - The running sum clears on reload/reset.
- Undefined:
  - No CHECK state; load_error is tied to 0.
  - DONE always asserts weights_ready.

Test Plan:
- Full load ramp:
  - Stimulus: weight byte i = i%256, biases k*1000.
  - Required: weights_ready rises exactly 1 cycle after byte 7880; byte_count=7880.
  - Required readback: weight_addr=785 -> 0x11 one cycle later; bias_addr=3 -> 3000.
- Bias endianness:
  - Stimulus: bias 0 bytes 0x78,0x56,0x34,0x12; bias 1 bytes 0xFF,0xFF,0xFF,0xFF.
  - Required: bias_data=0x12345678 and 0xFFFFFFFF (-1).
- Out of range and busy reads:
  - weight_addr=7840 -> 0; bias_addr=12 -> 0.
  - Extra rx_valid bytes after DONE -> byte_count stays 7880 and RAM is unchanged.
- reload collision:
  - Stimulus: reload asserted at byte 5000 with rx_valid high in the same cycle.
  - Required: weights_ready=0 and byte_count=0; the following full load succeeds with new data visible at addr 0.
- Async reset mid-bias: assert rst after 2 bytes of bias 4 -> outputs return to reset values immediately; a subsequent full load completes normally.
- Checksum, with WEIGHT_LOADER_CHECKSUM_EN defined:
  - Correct sum byte -> weights_ready=1, load_error=0.
  - Corrupted sum (+1) -> weights_ready=0, load_error=1, cleared by reload.
